// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types and constants for the FPU result capture path.
//               Unit index constants follow the bit order of the one-hot
//               unit-valid vector {sqrt,div,fma,mul,addsub,f2i,i2f,minmax,
//               cmp,sinj,fclass}, i.e. fclass is bit 0 and sqrt is bit 10.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int FPU_UNIT_W = 11;
  localparam int EXC_W      = 5;

  localparam logic [3:0] UNIT_FCLASS = 4'd0;
  localparam logic [3:0] UNIT_SINJ   = 4'd1;
  localparam logic [3:0] UNIT_CMP    = 4'd2;
  localparam logic [3:0] UNIT_MINMAX = 4'd3;
  localparam logic [3:0] UNIT_I2F    = 4'd4;
  localparam logic [3:0] UNIT_F2I    = 4'd5;
  localparam logic [3:0] UNIT_ADDSUB = 4'd6;
  localparam logic [3:0] UNIT_MUL    = 4'd7;
  localparam logic [3:0] UNIT_FMA    = 4'd8;
  localparam logic [3:0] UNIT_DIV    = 4'd9;
  localparam logic [3:0] UNIT_SQRT   = 4'd10;
  localparam logic [3:0] UNIT_BAD    = 4'hF;

  // One captured result, 44 bits.
  typedef struct packed {
    logic [31:0]      data;
    logic [EXC_W-1:0] exc;
    logic [3:0]       unit;
    logic [1:0]       op;
    logic             illegal;
  } fpu_res_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_unit_encode.sv
`default_nettype none
// ============================================================================
// Module      : fpu_unit_encode
// Description : Converts the 11-bit one-hot unit-valid vector into a 4-bit
//               unit index and flags vectors that are zero or multi-hot.
// Ports       : i_onehot    [10:0] one-hot unit-valid vector
//               o_code      [3:0]  index of the set bit (meaningful only
//                                  when o_malformed is 0)
//               o_malformed        1 when zero or more than one bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_unit_encode
  import fpu_pkg::*;
(
  input  logic [FPU_UNIT_W-1:0] i_onehot,
  output logic [3:0]            o_code,
  output logic                  o_malformed
);

  logic [3:0] w_idx;
  logic [3:0] w_hits;

  // Scan all bits, remembering the last set index and how many were set.
  always_comb begin
    w_idx  = 4'd0;
    w_hits = 4'd0;
    for (int i = 0; i < FPU_UNIT_W; i++) begin
      if (i_onehot[i]) begin
        w_idx  = 4'(i);
        w_hits = w_hits + 4'd1;
      end
    end
  end

  assign o_malformed = (w_hits != 4'd1);
  assign o_code      = w_idx;

endmodule : fpu_unit_encode
`default_nettype wire

// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_fifo
// Description : First-word-fall-through capture FIFO for completed FPU
//               results. Each result strobe is encoded into an fpu_res_t and
//               queued; a consumer drains the head with valid/ready. Results
//               arriving while full (with no same-cycle pop) are dropped and
//               counted.
// Ports       : clk, rst            clock, synchronous active-high reset
//               res_valid/res_*     result strobe and fields (push side)
//               clear               synchronous flush
//               out_valid/out_ready head handshake
//               out_*               head entry fields (0 when empty)
//               count, full         occupancy 0..DEPTH, full flag
//               overflow, drop_cnt  sticky drop flag, saturating drop count
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  input  logic [31:0]           res_data,
  input  logic [EXC_W-1:0]      res_exc,
  input  logic [FPU_UNIT_W-1:0] res_unit,
  input  logic [1:0]            res_op,
  input  logic                  res_illegal,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [EXC_W-1:0]      out_exc,
  output logic [3:0]            out_unit,
  output logic [1:0]            out_op,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   C_PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Pointers carry one wrap bit above the index; occupancy comes from count.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  fpu_res_t         mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Push-side entry encode
  // --------------------------------------------------------------------------
  logic [3:0] w_code;
  logic       w_malformed;
  fpu_res_t   w_entry;

  fpu_unit_encode u_unit_encode (
    .i_onehot    (res_unit),
    .o_code      (w_code),
    .o_malformed (w_malformed)
  );

  // Illegal ops carry no meaningful payload, so data and flags are zeroed;
  // unit and op are kept so software can still see what was attempted.
  always_comb begin
    w_entry.data    = res_illegal ? 32'd0 : res_data;
    w_entry.exc     = res_illegal ? '0    : res_exc;
    w_entry.unit    = w_malformed ? UNIT_BAD : w_code;
    w_entry.op      = res_op;
    w_entry.illegal = res_illegal;
  end

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_CNT_FULL);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign w_push  = res_valid && (!w_full || w_pop);
  assign w_drop  = res_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
      if (w_drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= w_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head falls through from storage, forced to zero when empty
  // --------------------------------------------------------------------------
  fpu_res_t w_head;

  assign w_head = w_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  assign out_valid   = !w_empty;
  assign out_data    = w_head.data;
  assign out_exc     = w_head.exc;
  assign out_unit    = w_head.unit;
  assign out_op      = w_head.op;
  assign out_illegal = w_head.illegal;
  assign count       = count_q;
  assign full        = w_full;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule : fpu_result_fifo
`default_nettype wire

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
Downstream capture stage for the FPU top-level. It latches every completed result, one entry per result strobe: the 32-bit result, 5-bit exception flags, the unit that produced it, the op code and the illegal-op flag. Entries go into a first-word-fall-through FIFO. A bus-side or GPIO-side consumer drains it with a valid/ready handshake, so multi-cycle div/sqrt results and back-to-back single-cycle results are not lost between register reads.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
res_valid  in  1  one-cycle strobe: a result is present this cycle
res_data  in  32  FPU result
res_exc  in  5  exception flags {NV,DZ,OF,UF,NX}
res_unit  in  11  one-hot unit valid vector {sqrt,div,fma,mul,addsub,f2i,i2f,minmax,cmp,sinj,fclass}
res_op  in  2  op qualifier
res_illegal  in  1  illegal-op indication for this result
clear  in  1  synchronous flush
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_data  out  32  head result
out_exc  out  5  head exceptions
out_unit  out  4  head unit code: 0..10 = bit index of res_unit; 15 = malformed
out_op  out  2  head op
out_illegal  out  1  head illegal flag
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
overflow  out  1  sticky: at least one result dropped
drop_cnt  out  8  dropped-result counter, saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge): pointers=0, count=0, overflow=0, drop_cnt=0. Outputs: out_valid=0, full=0, out_data/out_exc/out_op/out_illegal=0, out_unit=0. Storage contents need no reset. rst has priority over everything else and may be asserted mid-stream; all queued entries are discarded.
- Entry encode (combinational on the push side):
  - unit code = index of the single set bit of res_unit.
  - res_unit zero or multi-hot -> unit=15.
  - res_illegal=1 -> data and exc stored as 0 regardless of the inputs; unit and op are stored as given.
- Push: res_valid && (!full || pop_this_cycle). Write at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because the pop frees the slot in the same edge.
  - When empty, there is no pop (out_valid=0); the push is accepted and count becomes 1.
- Drop: res_valid && full && !pop.
  - Entry discarded, overflow <= 1, drop_cnt <= min(drop_cnt+1, 255).
  - Existing entries are untouched.
- clear=1 (rst=0):
  - pointers=0, count=0, overflow=0, drop_cnt=0.
  - Any same-cycle push or pop is ignored; clear wins.
- FWFT timing:
  - out_* show the head combinationally from storage at rd_ptr; out_valid = (count != 0).
  - A push into an empty FIFO gives out_valid=1 on the next cycle: latency 1.
  - Head fields are held stable while out_valid && !out_ready.
  - When empty, out_data/out_exc/out_op/out_illegal are driven 0 and out_unit is driven 0.
- count is a registered up/down counter, never outside 0..DEPTH. Pointers carry an extra wrap bit; full/empty derive from count.
- No state machine beyond the pointer/counter datapath. Throughput: one push and one pop per cycle sustained.

Decomposition:
- fpu_pkg holds:
  - FPU_UNIT_W=11 and the unit index constants UNIT_FCLASS=0 .. UNIT_SQRT=10.
  - UNIT_BAD=4'hF.
  - EXC_W=5.
  - typedef fpu_res_t: packed struct {data[31:0], exc[4:0], unit[3:0], op[1:0], illegal}, 44 bits.
- One sub-module, fpu_unit_encode: 11-bit one-hot to 4-bit code with malformed detection. It is reusable by the status registers block.
- Storage is an inline array of fpu_res_t.

Test Plan:
- Reset then idle -> out_valid=0, count=0, full=0, overflow=0, drop_cnt=0.
- Single push: res_data=32'h3F800000, exc=5'b00001, unit=11'h040, op=2'b01, out_ready=0 -> next cycle out_valid=1, out_data=3F800000, out_unit=6, out_op=1, count=1. Fields hold for 3 cycles until out_ready=1; then count=0.
- Fill DEPTH=8 with data 1..8, then push 9 and 10 while out_ready=0 -> full=1, overflow=1, drop_cnt=2. Drain yields 1..8 in order.
- Full, then res_valid and out_ready in the same cycle with data 32'hAA -> count stays 8, no drop. After draining, 32'hAA appears last.
- Encode corners:
  - res_unit=0 -> out_unit=15.
  - res_unit=11'h003 -> out_unit=15.
  - res_illegal=1 with data=32'hDEADBEEF, exc=5'h1F -> out_data=0, out_exc=0, out_illegal=1.
- Flush priority:
  - count=5, overflow=1; assert clear together with res_valid and out_ready -> next cycle count=0, overflow=0, drop_cnt=0, out_valid=0.
  - Mid-stream rst with count=3 gives the same empty state.
